// File: rtl/pc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS program-counter unit:
// next-PC selects, cause codes, FSM states and default vectors.
package pc_control_pkg;

    localparam int unsigned PC_SRC_W = 2;
    localparam int unsigned CAUSE_W  = 5;
    localparam int unsigned JIDX_W   = 26;

    typedef enum logic [PC_SRC_W-1:0] {
        PC_SRC_ALU_RESULT = 2'd0,
        PC_SRC_ALU_OUT    = 2'd1,
        PC_SRC_JUMP       = 2'd2,
        PC_SRC_REG        = 2'd3
    } pc_src_e;

    localparam logic [CAUSE_W-1:0] CAUSE_INT     = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ADEL    = 5'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_ADES    = 5'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_SYSCALL = 5'd8;
    localparam logic [CAUSE_W-1:0] CAUSE_BP      = 5'd9;
    localparam logic [CAUSE_W-1:0] CAUSE_RI      = 5'd10;
    localparam logic [CAUSE_W-1:0] CAUSE_OV      = 5'd12;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_control_pc_reg.sv
// Enabled WIDTH-bit register with asynchronous active-high reset to a
// parameterised value; used for pc, epc and bad_vaddr.
module pc_reg #(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_control.sv
// Program-counter unit: gated next-PC selection, alignment checking,
// RUN/EXC exception handling with EPC/Cause/BadVAddr, retired counter.
module pc_control
    import pc_control_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned      CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 pc_write_cond,
    input  logic                 branch_ne,
    input  logic                 zero,
    input  logic [PC_SRC_W-1:0]  pc_src,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic [JIDX_W-1:0]    jump_index,
    input  logic [WIDTH-1:0]     reg_target,
    input  logic                 exc_req,
    input  logic [CAUSE_W-1:0]   exc_cause,
    input  logic                 eret,
    input  logic                 retire,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     epc,
    output logic [CAUSE_W-1:0]   cause,
    output logic [WIDTH-1:0]     bad_vaddr,
    output logic                 in_exc,
    output logic                 double_fault,
    output logic [CNT_WIDTH-1:0] retired
);

    pc_state_e          r_state;
    pc_state_e          w_state_nxt;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_double_fault;
    logic [CNT_WIDTH-1:0] r_retired;

    logic [WIDTH-1:0]   w_pc;
    logic [WIDTH-1:0]   w_epc;
    logic [WIDTH-1:0]   w_target;
    logic               w_take;
    logic               w_misalign;

    logic               w_pc_en;
    logic [WIDTH-1:0]   w_pc_d;
    logic               w_epc_en;
    logic               w_bad_en;
    logic               w_cause_en;
    logic [CAUSE_W-1:0] w_cause_d;
    logic               w_df_set;

    // Next-PC candidate and the branch/jump qualification
    always_comb begin
        w_target = alu_result;
        case (pc_src_e'(pc_src))
            PC_SRC_ALU_RESULT: w_target = alu_result;
            PC_SRC_ALU_OUT:    w_target = alu_out;
            PC_SRC_JUMP:       w_target = {w_pc[WIDTH-1:28], jump_index, 2'b00};
            PC_SRC_REG:        w_target = reg_target;
        endcase
    end

    assign w_take     = pc_write | (pc_write_cond & (zero ^ branch_ne));
    assign w_misalign = w_take & (w_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Exception entry outranks eret, which outranks an ordinary PC update
    always_comb begin
        w_state_nxt = r_state;
        w_pc_en     = 1'b0;
        w_pc_d      = w_target;
        w_epc_en    = 1'b0;
        w_bad_en    = 1'b0;
        w_cause_en  = 1'b0;
        w_cause_d   = CAUSE_ADEL;
        w_df_set    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (exc_req || w_misalign) begin
                    w_state_nxt = ST_EXC;
                    w_pc_en     = 1'b1;
                    w_pc_d      = EXC_VECTOR;
                    w_epc_en    = 1'b1;
                    w_cause_en  = 1'b1;
                    w_cause_d   = exc_req ? exc_cause : CAUSE_ADEL;
                    w_bad_en    = w_misalign;
                end else if (w_take) begin
                    w_pc_en = 1'b1;
                end
            end
            ST_EXC: begin
                w_df_set = exc_req;
                if (eret) begin
                    w_state_nxt = ST_RUN;
                    w_pc_en     = 1'b1;
                    w_pc_d      = w_epc;
                end else if (w_take) begin
                    // A misaligned target inside the handler cannot re-enter
                    if (w_misalign) begin
                        w_df_set = 1'b1;
                    end else begin
                        w_pc_en = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    pc_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VECTOR)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_pc_en),
        .i_d   (w_pc_d),
        .o_q   (w_pc)
    );

    pc_reg #(.WIDTH(WIDTH), .RESET_VALUE('0)) u_epc_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_epc_en),
        .i_d   (w_pc),
        .o_q   (w_epc)
    );

    pc_reg #(.WIDTH(WIDTH), .RESET_VALUE('0)) u_bad_vaddr_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_bad_en),
        .i_d   (w_target),
        .o_q   (bad_vaddr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cause        <= '0;
            r_double_fault <= 1'b0;
        end else begin
            if (w_cause_en) begin
                r_cause <= w_cause_d;
            end
            if (w_df_set) begin
                r_double_fault <= 1'b1;
            end
        end
    end

    // Retired-instruction counter, free-running and wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (retire) begin
            r_retired <= r_retired + CNT_WIDTH'(1);
        end
    end

    assign pc           = w_pc;
    assign epc          = w_epc;
    assign cause        = r_cause;
    assign in_exc       = (r_state == ST_EXC);
    assign double_fault = r_double_fault;
    assign retired      = r_retired;

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: branch/jump selection, misalignment
// entry, EXC behaviour, eret, counter wrap and asynchronous reset.
module tb_pc_control;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned CNT_WIDTH = 4;

    logic                 clk;
    logic                 reset;
    logic                 pc_write;
    logic                 pc_write_cond;
    logic                 branch_ne;
    logic                 zero;
    logic [1:0]           pc_src;
    logic [WIDTH-1:0]     alu_result;
    logic [WIDTH-1:0]     alu_out;
    logic [25:0]          jump_index;
    logic [WIDTH-1:0]     reg_target;
    logic                 exc_req;
    logic [4:0]           exc_cause;
    logic                 eret;
    logic                 retire;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     epc;
    logic [4:0]           cause;
    logic [WIDTH-1:0]     bad_vaddr;
    logic                 in_exc;
    logic                 double_fault;
    logic [CNT_WIDTH-1:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    pc_control #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .pc_src        (pc_src),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .jump_index    (jump_index),
        .reg_target    (reg_target),
        .exc_req       (exc_req),
        .exc_cause     (exc_cause),
        .eret          (eret),
        .retire        (retire),
        .pc            (pc),
        .epc           (epc),
        .cause         (cause),
        .bad_vaddr     (bad_vaddr),
        .in_exc        (in_exc),
        .double_fault  (double_fault),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; branch_ne = 0; zero = 0;
        pc_src = 2'd0; exc_req = 0; exc_cause = 5'd0; eret = 0; retire = 0;
    endtask

    initial begin
        reset = 1'b1;
        alu_result = '0; alu_out = '0; jump_index = '0; reg_target = '0;
        idle();
        #23;
        check("rst_pc",        pc,                32'h0040_0000);
        check("rst_epc",       epc,               32'h0);
        check("rst_cause",     32'(cause),        32'h0);
        check("rst_bad",       bad_vaddr,         32'h0);
        check("rst_in_exc",    32'(in_exc),       32'h0);
        check("rst_df",        32'(double_fault), 32'h0);
        check("rst_retired",   32'(retired),      32'h0);

        @(posedge clk); #1;
        reset = 1'b0;
        check("pc_after_rel",  pc, 32'h0040_0000);

        // Sequential fetch
        pc_write = 1; pc_src = 2'd0; alu_result = 32'h0040_0004;
        tick();
        check("pc_plus4",      pc, 32'h0040_0004);
        check("retired_zero",  32'(retired), 32'h0);
        alu_result = 32'h0040_0010;
        tick();
        check("pc_0010",       pc, 32'h0040_0010);

        // BEQ taken, then BNE not taken on the same flag
        idle();
        pc_write_cond = 1; zero = 1; branch_ne = 0; pc_src = 2'd1; alu_out = 32'h0040_0100;
        tick();
        check("beq_taken",     pc, 32'h0040_0100);
        branch_ne = 1; alu_out = 32'h0040_0200;
        tick();
        check("bne_not_taken", pc, 32'h0040_0100);

        // Jump target concatenation
        idle();
        pc_write = 1; pc_src = 2'd0; alu_result = 32'h0040_0008;
        tick();
        check("pc_0008",       pc, 32'h0040_0008);
        pc_src = 2'd2; jump_index = 26'h000_0040;
        tick();
        check("jump_target",   pc, 32'h0000_0100);

        // Misaligned JR target enters EXC
        pc_src = 2'd3; reg_target = 32'h0040_0202;
        tick();
        check("misal_pc",      pc,          32'h8000_0180);
        check("misal_epc",     epc,         32'h0000_0100);
        check("misal_cause",   32'(cause),  32'h4);
        check("misal_bad",     bad_vaddr,   32'h0040_0202);
        check("misal_in_exc",  32'(in_exc), 32'h1);
        check("misal_df",      32'(double_fault), 32'h0);

        // Exception request inside the handler
        idle();
        exc_req = 1; exc_cause = 5'd12;
        tick();
        check("dbl_df",        32'(double_fault), 32'h1);
        check("dbl_epc",       epc,        32'h0000_0100);
        check("dbl_cause",     32'(cause), 32'h4);
        check("dbl_pc",        pc,         32'h8000_0180);

        // Handler advances; misaligned target there is suppressed
        idle();
        pc_write = 1; pc_src = 2'd0; alu_result = 32'h8000_0184;
        tick();
        check("exc_advance",   pc, 32'h8000_0184);
        alu_result = 32'h8000_0186;
        tick();
        check("exc_misal_pc",  pc, 32'h8000_0184);
        check("exc_misal_bad", bad_vaddr, 32'h0040_0202);
        check("exc_misal_st",  32'(in_exc), 32'h1);

        // eret returns to epc
        idle();
        eret = 1;
        tick();
        check("eret_pc",       pc, 32'h0000_0100);
        check("eret_in_exc",   32'(in_exc), 32'h0);
        tick();
        check("eret_run_pc",   pc, 32'h0000_0100);
        check("eret_run_st",   32'(in_exc), 32'h0);

        // exc_req beats pc_write in RUN
        idle();
        exc_req = 1; exc_cause = 5'd8; pc_write = 1; alu_result = 32'h0000_0104;
        tick();
        check("exc_pc",        pc,         32'h8000_0180);
        check("exc_epc",       epc,        32'h0000_0100);
        check("exc_cause",     32'(cause), 32'h8);
        check("exc_bad_hold",  bad_vaddr,  32'h0040_0202);

        // eret with exc_req in EXC: return taken
        idle();
        eret = 1; exc_req = 1; exc_cause = 5'd10;
        tick();
        check("eret_req_pc",   pc, 32'h0000_0100);
        check("eret_req_st",   32'(in_exc), 32'h0);
        check("eret_req_cause", 32'(cause), 32'h8);

        // Counter wrap at CNT_WIDTH=4
        idle();
        retire = 1;
        for (int i = 0; i < 15; i++) tick();
        check("ret_allones",   32'(retired), 32'hF);
        tick();
        check("ret_wrap",      32'(retired), 32'h0);
        pc_write = 1; alu_result = 32'h0000_0200;
        tick();
        check("ret_one",       32'(retired), 32'h1);
        check("pc_0200",       pc, 32'h0000_0200);

        // Asynchronous reset mid-cycle
        idle();
        #2;
        reset = 1'b1;
        #1;
        check("arst_pc",       pc,                32'h0040_0000);
        check("arst_epc",      epc,               32'h0);
        check("arst_cause",    32'(cause),        32'h0);
        check("arst_bad",      bad_vaddr,         32'h0);
        check("arst_in_exc",   32'(in_exc),       32'h0);
        check("arst_df",       32'(double_fault), 32'h0);
        check("arst_retired",  32'(retired),      32'h0);

        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        check("post_rst_pc",   pc, 32'h0040_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_control.md
# pc_control

Parameterised program-counter unit for the multi-cycle MIPS datapath. It replaces the bare PC flip-flop with these functions:
- PCWrite/PCWriteCond gating and next-PC source selection.
- Word-alignment checking.
- A two-state exception mechanism with EPC/Cause/BadVAddr capture and ERET return.
- A retired-instruction counter.

It sits between the control FSM, the ALU and the instruction-memory address port.

## Interface
- WIDTH, 32, PC/data width; must be ≥ 32
- RESET_VECTOR, 32'h0040_0000, PC value after reset
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception entry
- CNT_WIDTH, 32, retired-instruction counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- pc_write  in  1  unconditional PC update
- pc_write_cond  in  1  conditional PC update (branch)
- branch_ne  in  1  0: branch taken on zero=1; 1: branch taken on zero=0
- zero  in  1  ALU zero flag
- pc_src  in  2  0 alu_result, 1 alu_out, 2 jump, 3 reg_target
- alu_result  in  WIDTH  combinational ALU output (PC+4)
- alu_out  in  WIDTH  registered ALU output (branch target)
- jump_index  in  26  J-format index
- reg_target  in  WIDTH  rs value for JR/JALR
- exc_req  in  1  exception request from control
- exc_cause  in  5  cause code accompanying exc_req
- eret  in  1  return from exception
- retire  in  1  one instruction completed
- pc  out  WIDTH  current PC
- epc  out  WIDTH  saved PC of faulting instruction
- cause  out  5  latched cause code
- bad_vaddr  out  WIDTH  misaligned target that faulted
- in_exc  out  1  1 while in EXC state
- double_fault  out  1  sticky; exception requested while in EXC
- retired  out  CNT_WIDTH  retired-instruction count, wraps

## Operation
- States:
  - RUN: normal operation.
  - EXC: in handler.
- The FSM leaves RUN only on exception entry and leaves EXC only on eret.

Next-PC target, by pc_src:
- 0: alu_result.
- 1: alu_out.
- 2: {pc[WIDTH-1:28], jump_index, 2'b00}.
- 3: reg_target.

Update conditions:
- take = pc_write | (pc_write_cond & (zero ^ branch_ne)).
- misalign = take & (target[1:0] != 0).

Priority per cycle, highest first:
1. reset → pc=RESET_VECTOR; epc, cause, bad_vaddr, retired = 0; in_exc=0; double_fault=0; state RUN.
2. Exception entry in RUN, on exc_req or misalign:
   - pc ← EXC_VECTOR; epc ← pc; state ← EXC.
   - cause ← exc_cause if exc_req, else 5'd4 (AdEL); exc_req wins if both.
   - bad_vaddr ← target if misalign, else unchanged.
   - The misaligned target is never loaded.
3. eret in EXC → pc ← epc; state ← RUN.
4. take → pc ← target. Applies in both states; a misaligned target in EXC is suppressed, pc is held and double_fault is set.

Behaviour in EXC:
- exc_req sets double_fault and is otherwise ignored; epc and cause are not overwritten.
- eret in RUN is ignored.
- eret together with exc_req in EXC: eret is taken and double_fault is set.

Retired-instruction counter:
- retired increments on retire in any state, independent of PC updates.
- Wraps from all-ones to 0.

## Timing
- All outputs registered; every update is visible one cycle after the qualifying edge.
- No combinational path from inputs to outputs.
- Reset acts immediately (asynchronous) and releases on the first edge after deassertion.
- Exception entry to first vector fetch: 1 cycle.
- eret to restored pc: 1 cycle.
- Branch-condition evaluation uses zero from the same cycle as pc_write_cond.

## Structure
- Shared package holds:
  - pc_src encodings.
  - Cause constants, including CAUSE_ADEL = 5'd4.
  - RUN/EXC state enum.
  - Default RESET_VECTOR/EXC_VECTOR constants.
- One sub-module: pc_reg, a WIDTH-wide register with async active-high reset, enable and parameter RESET_VALUE. Instantiated for pc, epc and bad_vaddr.
- FSM, next-PC mux and counter live in pc_control.

## Test plan
- Reset, then pc_write=1, pc_src=0, alu_result=0x0040_0004 → pc=0x0040_0000 after reset; pc=0x0040_0004 next cycle; retired=0.
- pc=0x0040_0010, pc_write_cond=1, zero=1, branch_ne=0, pc_src=1, alu_out=0x0040_0100 → pc=0x0040_0100. Same stimulus with branch_ne=1 → pc unchanged.
- pc_src=2, jump_index=26'h000_0040, pc=0x0040_0008 → pc=0x0000_0100. Then pc_src=3, reg_target=0x0040_0202 → pc=0x8000_0180, epc=0x0000_0100, cause=4, bad_vaddr=0x0040_0202, in_exc=1.
- In EXC, exc_req with cause 12 → double_fault=1, epc/cause unchanged. eret → pc=epc, in_exc=0.
- In RUN, exc_req and pc_write in the same cycle → exception wins: pc=0x8000_0180, epc=old pc, cause=exc_cause.
- retired preset to all-ones by driving retire 2^CNT_WIDTH−1 times (CNT_WIDTH=4), one more retire → retired=0; mid-operation reset → all outputs at reset values.
